switch_port_arbiter: RTL

SWITCH_PORT_ARBITER -- requirements
Module: switch_port_arbiter

---
 rtl/switch_port_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/switch_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | switch_port_arbiter: four-requester round-robin output arbiter   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module switch_port_arbiter #(
  parameter int         DW   = 4,
  parameter logic [2:0] PORT = 3'd0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_0,
  input  logic          req_valid_1,
  input  logic          req_valid_2,
  input  logic          req_valid_3,
  input  logic [2:0]    req_adr_0,
  input  logic [2:0]    req_adr_1,
  input  logic [2:0]    req_adr_2,
  input  logic [2:0]    req_adr_3,
  input  logic [DW-1:0] req_dat_0,
  input  logic [DW-1:0] req_dat_1,
  input  logic [DW-1:0] req_dat_2,
  input  logic [DW-1:0] req_dat_3,
  output logic          req_ack_0,
  output logic          req_ack_1,
  output logic          req_ack_2,
  output logic          req_ack_3,
  output logic [DW-1:0] out_dat,
  output logic          out_valid,
  input  logic          out_ack,
  output logic [3:0]    grant,
  output logic          busy,
  output logic [7:0]    xfer_cnt
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t        state_q;
  logic [1:0]    ptr_q;
  logic          arm_q;
  logic [3:0]    ack_q;
  logic [3:0]    grant_q;
  logic [DW-1:0] dat_q;
  logic          valid_q;
  logic          busy_q;
  logic [7:0]    cnt_q;

  logic [3:0]    w_elig;
  logic [DW-1:0] w_dat [4];
  logic          w_any;
  logic [1:0]    w_win;
  logic [1:0]    w_cand;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_elig[0] = req_valid_0 && (req_adr_0 == PORT);
    w_elig[1] = req_valid_1 && (req_adr_1 == PORT);
    w_elig[2] = req_valid_2 && (req_adr_2 == PORT);
    w_elig[3] = req_valid_3 && (req_adr_3 == PORT);
    w_dat[0]  = req_dat_0;
    w_dat[1]  = req_dat_1;
    w_dat[2]  = req_dat_2;
    w_dat[3]  = req_dat_3;
    w_any     = |w_elig;
    w_win     = ptr_q;
    w_cand    = '0;
    for (int i = 4; i >= 1; i--) begin
      w_cand = ptr_q + 2'(i);
      if (w_elig[w_cand]) w_win = w_cand;
    end
  end

  // arm_q forces one dead IDLE edge after reset release and after each completion.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd3;
      arm_q   <= 1'b0;
      ack_q   <= '0;
      grant_q <= '0;
      dat_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (!arm_q) begin
            arm_q <= 1'b1;
          end else if (w_any) begin
            state_q <= S_SEND;
            ptr_q   <= w_win;
            dat_q   <= w_dat[w_win];
            ack_q   <= 4'b0001 << w_win;
            grant_q <= 4'b0001 << w_win;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_SEND: begin
          if (out_ack) begin
            state_q <= S_IDLE;
            arm_q   <= 1'b0;
            grant_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ack_0 = ack_q[0];
  assign req_ack_1 = ack_q[1];
  assign req_ack_2 = ack_q[2];
  assign req_ack_3 = ack_q[3];
  assign out_dat   = dat_q;
  assign out_valid = valid_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign xfer_cnt  = cnt_q;

endmodule
`default_nettype wire
